axis_fifo_frame_arbiter: RTL and testbench
==========================================

Name: axis_fifo_frame_arbiter

Overview:
Frame-granular round-robin arbiter that shares one AXI4-Stream FIFO/width-adapter instance between N upstream requesters. It grants one input at a time and holds the grant until tlast, so frames never interleave. The port index is carried on m_axis_tid. It throttles new grants from the downstream FIFO's status_depth using high/low watermarks with hysteresis. It sits directly upstream of the FIFO adapter's s_axis port.

Parameters:
- PORTS, 4, number of requesters (2..16)
- DATA_WIDTH, 64, tdata width per port and output
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, m_axis_tkeep is driven all-ones
- KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width
- USER_WIDTH, 1, tuser width, passed through
- DEPTH_WIDTH, 13, width of the fifo_status_depth input
- HIGH_WATERMARK, 3072, depth at or above which new grants are suppressed
- LOW_WATERMARK, 2048, depth at or below which suppression is released (must be < HIGH_WATERMARK)
- SEL_WIDTH, $clog2(PORTS) (minimum 1), index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  PORTS*DATA_WIDTH  packed per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  PORTS*KEEP_WIDTH  packed keep
- s_axis_tvalid  in  PORTS  per-port valid
- s_axis_tready  out  PORTS  per-port ready
- s_axis_tlast  in  PORTS  per-port last
- s_axis_tuser  in  PORTS*USER_WIDTH  packed user
- m_axis_tdata  out  DATA_WIDTH  to FIFO
- m_axis_tkeep  out  KEEP_WIDTH  to FIFO
- m_axis_tvalid  out  1  to FIFO
- m_axis_tready  in  1  from FIFO
- m_axis_tlast  out  1  to FIFO
- m_axis_tid  out  SEL_WIDTH  granted port index
- m_axis_tuser  out  USER_WIDTH  to FIFO
- fifo_status_depth  in  DEPTH_WIDTH  FIFO status_depth
- grant_valid  out  1  a frame is currently granted
- grant_index  out  SEL_WIDTH  current/last granted port
- throttle  out  1  watermark suppression active
- frame_count  out  32  completed frames, wraps at 2^32

Behaviour:
- The clock and reset are fixed: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, grant_valid=0, grant_index=PORTS-1 (so port 0 wins first), throttle=0, frame_count=0. All s_axis_tready=0 and m_axis_tvalid=0 while rst is high or in IDLE.
- The FSM has two states.
- IDLE: if !throttle and any s_axis_tvalid, register the next requester in round-robin order, searching from grant_index+1 modulo PORTS. Set grant_valid=1 and go to PASS. If nothing is requesting, or throttle=1, stay in IDLE.
- PASS: combinational mux of the granted port.
  - m_axis_tvalid = s_axis_tvalid[g]; s_axis_tready[g] = m_axis_tready; all other readies are 0.
  - tdata, tkeep, tlast and tuser come from port g; m_axis_tid = g.
  - On a transfer with tlast: clear grant_valid, increment frame_count, return to IDLE.
- Latency: zero cycles through the datapath. There is a one-cycle arbitration bubble between frames, so the minimum gap is one idle cycle after each tlast beat.
- Grant lock: the grant is not revoked mid-frame for any reason (throttle, other requesters, s_tvalid dropping). Only tlast or rst ends it.
- Throttle register, updated every cycle:
  - set when fifo_status_depth >= HIGH_WATERMARK;
  - clear when fifo_status_depth <= LOW_WATERMARK;
  - otherwise hold.
  - It gates only the IDLE->PASS transition.
- Single-beat frame (tlast on the first beat): one PASS cycle, back to IDLE on the next cycle.
- Requester deasserting tvalid before its grant: if it is not requesting in the IDLE evaluation cycle, it is skipped.
- Simultaneous requests: fairness is round-robin, so no port is granted twice while another port continuously requests.
- Reset mid-frame: the grant is dropped immediately. Upstream must also restart frames; the partial frame seen by the FIFO is the integrator's concern, since FIFO rst is shared.
- Pointer wrap: grant_index PORTS-1 -> 0.
- frame_count wraps silently.
- Widths: comparisons are unsigned DEPTH_WIDTH.

Decomposition:
- Shared package axis_arb_pkg holds the FSM state enum (IDLE, PASS) and the function rr_next(req, last) that returns the next index.
- Sub-module: arb_rr_select, a combinational priority rotate and encode (PORTS requests plus last index -> next index and found flag). It is reusable by other AXIS muxes.
- The top level holds the FSM, watermark register, counters and datapath mux.

Test Plan:
- PORTS=4, ports 0 and 2 each send 3-beat frames continuously, m_tready=1 -> output order p0,p2,p0,p2. m_tid matches the source. One bubble cycle between frames. frame_count=4 after four frames.
- All 4 ports request from reset -> grants in order 0,1,2,3,0. No interleaving of beats within a frame (check tid is constant until tlast).
- Mid-frame on port 1, drive depth to 3072 -> the frame completes. After tlast, stay IDLE with throttle=1 while depth is 2500. Drop depth to 2048 -> throttle clears, and the next grant is issued one cycle later.
- Granted port withholds tvalid for 5 cycles mid-frame while port 3 requests -> the grant is held, m_tvalid=0, and port 3 sees tready=0 throughout.
- Random m_tready backpressure of 50% with random frames on all ports -> data, keep, user and last are bit-exact per port against a scoreboard, and no beat is lost or duplicated.
- Assert rst on the 2nd beat of a 4-beat frame -> the next cycle has all tready=0, grant_valid=0, frame_count=0, grant_index=3. The first grant after release goes to port 0.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for frame-granular AXI4-Stream arbiters.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  localparam int RR_MAX_PORTS = 16;

  // Next requester after 'last' in round-robin order; returns 'last' when nobody requests.
  function automatic logic [3:0] rr_next(input logic [RR_MAX_PORTS-1:0] req,
                                         input int ports,
                                         input logic [3:0] last);
    logic [3:0] nxt;
    logic       hit;
    logic [4:0] cand;
    nxt = last;
    hit = 1'b0;
    for (int k = 1; k <= RR_MAX_PORTS; k++) begin
      cand = 5'(last) + 5'(k);
      if (cand >= 5'(ports)) cand = cand - 5'(ports);
      if (k <= ports && !hit && req[cand[3:0]]) begin
        nxt = cand[3:0];
        hit = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/axis_fifo_frame_arbiter_rr_select.sv
// Combinational round-robin rotate/encode: request vector plus last index -> next index.
module arb_rr_select
  import axis_arb_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [PORTS-1:0]     req_i,
  input  logic [SEL_WIDTH-1:0] last_i,
  output logic [SEL_WIDTH-1:0] next_o,
  output logic                 found_o
);

  logic [RR_MAX_PORTS-1:0] req_w;
  logic [3:0]              next_w;

  assign req_w   = RR_MAX_PORTS'(req_i);
  assign next_w  = rr_next(req_w, PORTS, 4'(last_i));
  assign next_o  = SEL_WIDTH'(next_w);
  assign found_o = |req_i;

endmodule

// File: rtl/axis_fifo_frame_arbiter.sv
// Frame-locked round-robin arbiter feeding one AXI4-Stream FIFO, with depth-watermark throttling.
module axis_fifo_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int PORTS          = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH     = ((DATA_WIDTH + 7) / 8),
  parameter int USER_WIDTH     = 1,
  parameter int DEPTH_WIDTH    = 13,
  parameter int HIGH_WATERMARK = 3072,
  parameter int LOW_WATERMARK  = 2048,
  parameter int SEL_WIDTH      = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [SEL_WIDTH-1:0]          m_axis_tid,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  input  logic [DEPTH_WIDTH-1:0]        fifo_status_depth,
  output logic                          grant_valid,
  output logic [SEL_WIDTH-1:0]          grant_index,
  output logic                          throttle,
  output logic [31:0]                   frame_count
);

  localparam logic [DEPTH_WIDTH-1:0] HIGH_WM = DEPTH_WIDTH'(HIGH_WATERMARK);
  localparam logic [DEPTH_WIDTH-1:0] LOW_WM  = DEPTH_WIDTH'(LOW_WATERMARK);

  arb_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0] grant_q, grant_d;
  logic [SEL_WIDTH-1:0] rr_idx;
  logic                 rr_found;
  logic                 throttle_q, throttle_d;
  logic [31:0]          frame_cnt_q, frame_cnt_d;
  logic                 passing;
  logic                 xfer_last;

  logic [DATA_WIDTH-1:0] tdata_arr [PORTS];
  logic [KEEP_WIDTH-1:0] tkeep_arr [PORTS];
  logic [USER_WIDTH-1:0] tuser_arr [PORTS];

  for (genvar i = 0; i < PORTS; i++) begin : g_unpack
    assign tdata_arr[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign tkeep_arr[i] = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
    assign tuser_arr[i] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
  end

  arb_rr_select #(
    .PORTS     (PORTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_select (
    .req_i   (s_axis_tvalid),
    .last_i  (grant_q),
    .next_o  (rr_idx),
    .found_o (rr_found)
  );

  // Handshakes are forced off while rst is high, even if the FSM still holds PASS.
  assign passing       = (state_q == PASS) && !rst;
  assign m_axis_tvalid = passing && s_axis_tvalid[grant_q];
  assign m_axis_tdata  = tdata_arr[grant_q];
  assign m_axis_tlast  = s_axis_tlast[grant_q];
  assign m_axis_tuser  = tuser_arr[grant_q];
  assign m_axis_tid    = grant_q;
  assign xfer_last     = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  if (KEEP_ENABLE != 0) begin : g_keep
    assign m_axis_tkeep = tkeep_arr[grant_q];
  end else begin : g_no_keep
    assign m_axis_tkeep = '1;
  end

  always_comb begin
    s_axis_tready = '0;
    if (passing) s_axis_tready[grant_q] = m_axis_tready;
  end

  // Throttle only blocks new grants; an open frame always runs to tlast.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (!throttle_q && rr_found) begin
          grant_d = rr_idx;
          state_d = PASS;
        end
      end
      PASS: begin
        if (xfer_last) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    throttle_d = throttle_q;
    if (fifo_status_depth >= HIGH_WM) throttle_d = 1'b1;
    else if (fifo_status_depth <= LOW_WM) throttle_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= SEL_WIDTH'(PORTS - 1);
      throttle_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      throttle_q  <= throttle_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign grant_valid = (state_q == PASS);
  assign grant_index = grant_q;
  assign throttle    = throttle_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_axis_fifo_frame_arbiter.sv
// Directed bench for axis_fifo_frame_arbiter: frame-level reference model plus per-port beat scoreboard.
module tb_axis_fifo_frame_arbiter;

  localparam int P  = 4;
  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        u;
    logic        l;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [P*DW-1:0]   s_axis_tdata  = '0;
  logic [P*KW-1:0]   s_axis_tkeep  = '0;
  logic [P-1:0]      s_axis_tvalid = '0;
  logic [P-1:0]      s_axis_tready;
  logic [P-1:0]      s_axis_tlast  = '0;
  logic [P-1:0]      s_axis_tuser  = '0;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic [1:0]        m_axis_tid;
  logic [0:0]        m_axis_tuser;
  logic [12:0]       fifo_status_depth = '0;
  logic              grant_valid;
  logic [1:0]        grant_index;
  logic              throttle;
  logic [31:0]       frame_count;

  axis_fifo_frame_arbiter #(
    .PORTS(P), .DATA_WIDTH(DW), .USER_WIDTH(1), .DEPTH_WIDTH(13),
    .HIGH_WATERMARK(3072), .LOW_WATERMARK(2048)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tuser(m_axis_tuser),
    .fifo_status_depth(fifo_status_depth),
    .grant_valid(grant_valid), .grant_index(grant_index),
    .throttle(throttle), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  beat_t       srcq [P][$];
  int          order_q [$];
  logic [P-1:0] en = '1;
  bit          rnd_ready = 0;
  int          beats_in = 0;
  int          beats_out = 0;

  // Reference model state: which port owns the output, watermark flag, completed frames.
  bit          model_ok = 0;
  bit          m_busy = 0;
  bit          m_thr = 0;
  int          m_g = P - 1;
  int unsigned m_cnt = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic drive();
    for (int p = 0; p < P; p++) begin
      if (srcq[p].size() > 0) begin
        s_axis_tvalid[p]           = en[p];
        s_axis_tdata[p*DW +: DW]   = srcq[p][0].d;
        s_axis_tkeep[p*KW +: KW]   = srcq[p][0].k;
        s_axis_tuser[p]            = srcq[p][0].u;
        s_axis_tlast[p]            = srcq[p][0].l;
      end else begin
        s_axis_tvalid[p] = 1'b0;
        s_axis_tlast[p]  = 1'b0;
      end
    end
  endtask

  task automatic add_frame(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom(), $urandom()};
      b.k = 8'($urandom());
      b.u = 1'($urandom());
      b.l = (i == len - 1);
      srcq[p].push_back(b);
      beats_in++;
    end
  endtask

  // One clock: compare at negedge, advance model to the coming edge, update sources after it.
  task automatic cycle();
    logic [P-1:0] exp_rdy;
    logic         exp_mv;
    logic [P-1:0] pf;
    beat_t        b;
    bit           found;
    int           nxt;
    bit           thr_n;
    @(negedge clk);
    exp_rdy = '0;
    exp_mv  = 1'b0;
    if (!rst && m_busy) begin
      exp_mv         = s_axis_tvalid[m_g];
      exp_rdy[m_g]   = m_axis_tready;
    end
    if (model_ok) begin
      chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_mv));
      chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
      chk("grant_valid", 64'(grant_valid), 64'(m_busy));
      chk("grant_index", 64'(grant_index), 64'(m_g));
      chk("throttle", 64'(throttle), 64'(m_thr));
      chk("frame_count", 64'(frame_count), 64'(m_cnt));
      if (exp_mv) begin
        b = srcq[m_g][0];
        chk("m_tdata", m_axis_tdata, b.d);
        chk("m_tkeep", 64'(m_axis_tkeep), 64'(b.k));
        chk("m_tuser", 64'(m_axis_tuser), 64'(b.u));
        chk("m_tlast", 64'(m_axis_tlast), 64'(b.l));
        chk("m_tid", 64'(m_axis_tid), 64'(m_g));
      end
    end
    if (m_axis_tvalid && m_axis_tready) beats_out++;
    pf = s_axis_tvalid & s_axis_tready;
    if (rst) begin
      model_ok = 1; m_busy = 0; m_thr = 0; m_g = P - 1; m_cnt = 0;
    end else begin
      if (fifo_status_depth >= 13'd3072)      thr_n = 1;
      else if (fifo_status_depth <= 13'd2048) thr_n = 0;
      else                                    thr_n = m_thr;
      if (m_busy) begin
        if (exp_mv && m_axis_tready && srcq[m_g][0].l) begin
          m_busy = 0;
          m_cnt++;
          order_q.push_back(m_g);
        end
      end else if (!m_thr && (|s_axis_tvalid)) begin
        found = 0;
        nxt   = m_g;
        for (int k = 1; k <= P; k++)
          if (!found && s_axis_tvalid[(m_g + k) % P]) begin
            nxt = (m_g + k) % P;
            found = 1;
          end
        m_g    = nxt;
        m_busy = 1;
      end
      m_thr = thr_n;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < P; p++)
      if (pf[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
    if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    for (int p = 0; p < P; p++) srcq[p].delete();
    order_q.delete();
    en = '1;
    rnd_ready = 0;
    m_axis_tready = 1'b1;
    fifo_status_depth = '0;
    beats_in = 0;
    beats_out = 0;
    drive();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic run_until_frames(input int unsigned n, input int budget);
    for (int i = 0; i < budget && m_cnt < n; i++) cycle();
    chk("frames_reached", 64'(m_cnt >= n), 64'd1);
  endtask

  task automatic chk_order(input string name, input int exp[$]);
    chk({name, "_count"}, 64'(order_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(name, 64'((i < order_q.size()) ? order_q[i] : 99), 64'(exp[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    // Reset state
    reset_dut();
    chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_grant_index", 64'(grant_index), 64'd3);
    chk("rst_throttle", 64'(throttle), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);

    // Ports 0 and 2 alternate, 3-beat frames, one bubble between frames
    reset_dut();
    add_frame(0, 3); add_frame(0, 3); add_frame(2, 3); add_frame(2, 3);
    drive();
    run_until_frames(4, 100);
    chk("t1_frame_count", 64'(frame_count), 64'd4);
    chk_order("t1_order", '{0, 2, 0, 2});

    // All four ports request from reset
    reset_dut();
    for (int p = 0; p < P; p++) add_frame(p, 2);
    add_frame(0, 2);
    drive();
    run_until_frames(5, 100);
    chk_order("t2_order", '{0, 1, 2, 3, 0});

    // Watermark hysteresis
    reset_dut();
    add_frame(1, 4); add_frame(1, 4);
    drive();
    for (int i = 0; i < 20 && beats_out < 2; i++) cycle();
    fifo_status_depth = 13'd3072;
    run_until_frames(1, 30);
    chk("t3_throttle_set", 64'(throttle), 64'd1);
    fifo_status_depth = 13'd2500;
    repeat (5) cycle();
    chk("t3_hold_idle", 64'(grant_valid), 64'd0);
    chk("t3_hold_thr", 64'(throttle), 64'd1);
    fifo_status_depth = 13'd2048;
    cycle();
    chk("t3_thr_clear", 64'(throttle), 64'd0);
    chk("t3_not_yet", 64'(grant_valid), 64'd0);
    cycle();
    chk("t3_regrant", 64'(grant_valid), 64'd1);
    chk("t3_regrant_idx", 64'(grant_index), 64'd1);
    fifo_status_depth = '0;
    run_until_frames(2, 30);

    // Granted port stalls mid-frame while port 3 waits
    reset_dut();
    add_frame(0, 4); add_frame(3, 2);
    drive();
    for (int i = 0; i < 20 && beats_out < 1; i++) cycle();
    en[0] = 1'b0;
    drive();
    repeat (5) begin
      cycle();
      chk("t4_mvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t4_p3_ready", 64'(s_axis_tready[3]), 64'd0);
      chk("t4_held", 64'(grant_valid), 64'd1);
      chk("t4_idx", 64'(grant_index), 64'd0);
    end
    en[0] = 1'b1;
    drive();
    run_until_frames(2, 40);
    chk_order("t4_order", '{0, 3});

    // Random frames on all ports with 50% downstream backpressure
    reset_dut();
    rnd_ready = 1;
    for (int p = 0; p < P; p++)
      for (int f = 0; f < 3; f++) add_frame(p, $urandom_range(1, 5));
    drive();
    for (int i = 0; i < 1000 && beats_out < beats_in; i++) cycle();
    rnd_ready = 0;
    m_axis_tready = 1'b1;
    repeat (2) cycle();
    chk("t5_beats", 64'(beats_out), 64'(beats_in));
    chk("t5_frames", 64'(frame_count), 64'd12);
    chk("t5_left", 64'(srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size()), 64'd0);

    // Reset on the second beat of a 4-beat frame
    reset_dut();
    add_frame(0, 1); add_frame(1, 4);
    drive();
    for (int i = 0; i < 30 && !(m_cnt >= 1 && beats_out >= 2); i++) cycle();
    chk("t6_pre_count", 64'(frame_count), 64'd1);
    chk("t6_pre_idx", 64'(grant_index), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_tready", 64'(s_axis_tready), 64'd0);
    chk("t6_gv", 64'(grant_valid), 64'd0);
    chk("t6_count", 64'(frame_count), 64'd0);
    chk("t6_idx", 64'(grant_index), 64'd3);
    srcq[1].delete();
    add_frame(1, 2); add_frame(0, 2);
    drive();
    cycle();
    chk("t6_first_grant", 64'(grant_index), 64'd0);
    chk("t6_first_gv", 64'(grant_valid), 64'd1);
    run_until_frames(2, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
